// File: rtl/fft_in_packer_pkg.sv
// Shared constants and types for the FFT input packer.
// Sample width, lane count and frame geometry live here.
package fft_pkg;

  localparam int DATA_W    = 11;
  localparam int LANES     = 16;
  localparam int FRAME_LEN = 512;
  localparam int BEATS     = FRAME_LEN / LANES;
  localparam int CNT_W     = $clog2(FRAME_LEN);
  localparam int LANE_W    = $clog2(LANES);

  typedef logic signed [DATA_W-1:0] sample_t;

  typedef enum logic {
    IDLE,
    FILL
  } state_t;

endpackage

// File: rtl/fft_in_packer_if.sv
// Sample stream in, 16-lane beat out.
// slave is the packer's view, master the producer/consumer view.
interface fft_in_packer_if;
  import fft_pkg::*;

  logic    sin_valid;
  logic    sin_sof;
  sample_t sin_i;
  sample_t sin_q;

  logic    dout_valid;
  logic    dout_sof;
  logic    dout_eof;
  logic    sync_err;
  sample_t dout_i [LANES];
  sample_t dout_q [LANES];

  modport slave (
    input  sin_valid, sin_sof,
    input  sin_i, sin_q,
    output dout_valid, dout_sof,
    output dout_eof, sync_err,
    output dout_i, dout_q
  );

  modport master (
    output sin_valid, sin_sof,
    output sin_i, sin_q,
    input  dout_valid, dout_sof,
    input  dout_eof, sync_err,
    input  dout_i, dout_q
  );

endinterface

// File: rtl/fft_in_packer.sv
// Packs serial complex samples into 16-lane beats,
// aligned to 512-sample frames by the sof marker.
module fft_in_packer
  import fft_pkg::*;
(
  input  logic            clk,
  input  logic            rstn,
  fft_in_packer_if.slave  bus
);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  sample_t fill_i_q [LANES];
  sample_t fill_i_d [LANES];
  sample_t fill_q_q [LANES];
  sample_t fill_q_d [LANES];
  sample_t out_i_q  [LANES];
  sample_t out_i_d  [LANES];
  sample_t out_q_q  [LANES];
  sample_t out_q_d  [LANES];

  logic vld_q, vld_d;
  logic sof_q, sof_d;
  logic eof_q, eof_d;
  logic err_q, err_d;

  logic [LANE_W-1:0] lane;
  logic              last_lane;
  logic              last_beat;
  logic              first_beat;

  assign lane       = cnt_q[LANE_W-1:0];
  assign last_lane  = lane == LANE_W'(LANES-1);
  assign last_beat  = cnt_q == CNT_W'(FRAME_LEN-1);
  assign first_beat = cnt_q[CNT_W-1:LANE_W] == '0;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    fill_i_d = fill_i_q;
    fill_q_d = fill_q_q;
    out_i_d  = out_i_q;
    out_q_d  = out_q_q;
    vld_d    = 1'b0;
    sof_d    = 1'b0;
    eof_d    = 1'b0;
    err_d    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.sin_valid && bus.sin_sof) begin
          fill_i_d[0] = bus.sin_i;
          fill_q_d[0] = bus.sin_q;
          cnt_d       = CNT_W'(1);
          state_d     = FILL;
        end
      end
      FILL: begin
        if (bus.sin_valid) begin
          if (bus.sin_sof && cnt_q != '0) begin
            // Resync: abandon the partial frame, sof becomes lane 0
            err_d       = 1'b1;
            fill_i_d[0] = bus.sin_i;
            fill_q_d[0] = bus.sin_q;
            cnt_d       = CNT_W'(1);
          end else begin
            fill_i_d[lane] = bus.sin_i;
            fill_q_d[lane] = bus.sin_q;
            cnt_d          = cnt_q + CNT_W'(1);
            if (last_lane) begin
              out_i_d = fill_i_d;
              out_q_d = fill_q_d;
              vld_d   = 1'b1;
              sof_d   = first_beat;
              eof_d   = last_beat;
              if (last_beat) begin
                state_d = IDLE;
                cnt_d   = '0;
              end
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      fill_i_q <= '{default: '0};
      fill_q_q <= '{default: '0};
      out_i_q  <= '{default: '0};
      out_q_q  <= '{default: '0};
      vld_q    <= 1'b0;
      sof_q    <= 1'b0;
      eof_q    <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      fill_i_q <= fill_i_d;
      fill_q_q <= fill_q_d;
      out_i_q  <= out_i_d;
      out_q_q  <= out_q_d;
      vld_q    <= vld_d;
      sof_q    <= sof_d;
      eof_q    <= eof_d;
      err_q    <= err_d;
    end
  end

  assign bus.dout_valid = vld_q;
  assign bus.dout_sof   = sof_q;
  assign bus.dout_eof   = eof_q;
  assign bus.sync_err   = err_q;
  assign bus.dout_i     = out_i_q;
  assign bus.dout_q     = out_q_q;

endmodule

// File: tb/tb_fft_in_packer.sv
// Bench for fft_in_packer: frame-level queue model
// compared every cycle, plus literal spot checks.
module tb_fft_in_packer;
  import fft_pkg::*;

  logic clk  = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  fft_in_packer_if bus();

  fft_in_packer dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus.slave)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;
  bit chk_en = 1'b0;

  bit nxt_v = 0, nxt_s = 0, nxt_e = 0, nxt_r = 0;
  bit exp_v = 0, exp_s = 0, exp_e = 0, exp_r = 0;
  sample_t hold_i [LANES];
  sample_t hold_q [LANES];
  sample_t exp_i  [LANES];
  sample_t exp_q  [LANES];

  sample_t frm_i [$];
  sample_t frm_q [$];
  bit      in_frame = 1'b0;

  int pulses [$];
  int n_err = 0;

  function automatic void check(string nm, int got, int want);
    n_cmp++;
    if (got != want) begin
      n_bad++;
      $display("FAIL %s: got %0d want %0d", nm, got, want);
    end
  endfunction

  function automatic bit gaps_ok(int g);
    for (int k = 1; k < pulses.size(); k++)
      if (pulses[k] - pulses[k-1] != g) return 1'b0;
    return 1'b1;
  endfunction

  // Model: keep the samples of the current frame; every 16th
  // one makes a beat of the last 16.
  task automatic step(input bit r, input bit v, input bit s,
                      input sample_t i, input sample_t q);
    rstn          = r;
    bus.sin_valid = v;
    bus.sin_sof   = s;
    bus.sin_i     = i;
    bus.sin_q     = q;
    nxt_v = 0; nxt_s = 0; nxt_e = 0; nxt_r = 0;
    if (!r) begin
      in_frame = 0;
      frm_i.delete();
      frm_q.delete();
      for (int j = 0; j < LANES; j++) begin
        hold_i[j] = '0;
        hold_q[j] = '0;
      end
    end else if (v) begin
      if (s) begin
        nxt_r    = in_frame;
        in_frame = 1;
        frm_i.delete();
        frm_q.delete();
      end
      if (in_frame) begin
        frm_i.push_back(i);
        frm_q.push_back(q);
        if (frm_i.size() % LANES == 0) begin
          for (int j = 0; j < LANES; j++) begin
            hold_i[j] = frm_i[frm_i.size()-LANES+j];
            hold_q[j] = frm_q[frm_q.size()-LANES+j];
          end
          nxt_v = 1;
          nxt_s = frm_i.size() == LANES;
          nxt_e = frm_i.size() == FRAME_LEN;
          if (nxt_e) begin
            in_frame = 0;
            frm_i.delete();
            frm_q.delete();
          end
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++)
      step(1, 0, 0, sample_t'($urandom), sample_t'($urandom));
  endtask

  task automatic clr();
    pulses.delete();
    n_err = 0;
  endtask

  always @(posedge clk) begin
    cyc   <= cyc + 1;
    exp_v <= nxt_v;
    exp_s <= nxt_s;
    exp_e <= nxt_e;
    exp_r <= nxt_r;
    exp_i <= hold_i;
    exp_q <= hold_q;
  end

  always @(negedge clk) begin
    int bl;
    if (chk_en) begin
      bl = -1;
      n_cmp++;
      if ({bus.dout_valid, bus.dout_sof, bus.dout_eof, bus.sync_err}
          !== {exp_v, exp_s, exp_e, exp_r}) begin
        n_bad++;
        $display("FAIL ctrl cyc %0d: vld/sof/eof/err got %b%b%b%b want %b%b%b%b",
                 cyc, bus.dout_valid, bus.dout_sof, bus.dout_eof,
                 bus.sync_err, exp_v, exp_s, exp_e, exp_r);
      end
      for (int j = LANES - 1; j >= 0; j--)
        if (bus.dout_i[j] !== exp_i[j] || bus.dout_q[j] !== exp_q[j])
          bl = j;
      n_cmp++;
      if (bl >= 0) begin
        n_bad++;
        $display("FAIL lanes cyc %0d lane %0d: got (%0d,%0d) want (%0d,%0d)",
                 cyc, bl, bus.dout_i[bl], bus.dout_q[bl],
                 exp_i[bl], exp_q[bl]);
      end
      if (bus.dout_valid === 1'b1) pulses.push_back(cyc);
      if (bus.sync_err === 1'b1) n_err++;
    end
  end

  initial begin
    int c15;
    bus.sin_valid = 0;
    bus.sin_sof   = 0;
    bus.sin_i     = '0;
    bus.sin_q     = '0;
    for (int j = 0; j < LANES; j++) begin
      hold_i[j] = '0;
      hold_q[j] = '0;
    end
    @(posedge clk);
    #1;
    step(0, 0, 0, '0, '0);
    chk_en = 1;
    step(0, 0, 0, '0, '0);
    step(0, 0, 0, '0, '0);

    // Continuous frame, i=n, q=-n
    clr();
    c15 = 0;
    for (int n = 0; n < FRAME_LEN; n++) begin
      if (n == 15) c15 = cyc;
      step(1, 1, n == 0, sample_t'(n), sample_t'(-n));
    end
    idle(3);
    check("t1_beats", pulses.size(), BEATS);
    check("t1_first", pulses.size() > 0 ? pulses[0] : -1, c15 + 1);
    check("t1_gap16", int'(gaps_ok(16)), 1);
    check("t1_last_i5", int'(bus.dout_i[5]), 501);
    check("t1_last_q5", int'(bus.dout_q[5]), -501);

    // Same frame, valid toggling
    clr();
    for (int n = 0; n < FRAME_LEN; n++) begin
      step(1, 1, n == 0, sample_t'(n), sample_t'(-n));
      step(1, 0, 1'($urandom), sample_t'($urandom), sample_t'($urandom));
    end
    idle(3);
    check("t2_beats", pulses.size(), BEATS);
    check("t2_gap32", int'(gaps_ok(32)), 1);
    check("t2_err", n_err, 0);

    // Back-to-back frames
    clr();
    for (int f = 0; f < 2; f++)
      for (int n = 0; n < FRAME_LEN; n++)
        step(1, 1, n == 0, sample_t'($urandom), sample_t'($urandom));
    idle(3);
    check("t3_beats", pulses.size(), 2 * BEATS);
    check("t3_gap16", int'(gaps_ok(16)), 1);

    // sof injected at sample 100
    clr();
    for (int n = 0; n < 100; n++)
      step(1, 1, n == 0, sample_t'(n), sample_t'(-n));
    for (int n = 0; n < FRAME_LEN; n++)
      step(1, 1, n == 0, sample_t'(1000 - n), sample_t'(n - 1000));
    idle(3);
    check("t4_err", n_err, 1);
    check("t4_beats", pulses.size(), 6 + BEATS);

    // Samples without sof are dropped
    clr();
    for (int n = 0; n < 40; n++)
      step(1, 1, 0, sample_t'($urandom), sample_t'($urandom));
    idle(2);
    check("t5_nobeat", pulses.size(), 0);
    check("t5_noerr", n_err, 0);
    for (int n = 0; n < 200; n++) begin
      if (n == 16) check("t5_lane0", int'(bus.dout_i[0]), 77);
      step(1, 1, n == 0, sample_t'(77 + n), sample_t'(-77 - n));
    end

    // Reset mid-frame
    step(0, 1, 1, sample_t'(5), sample_t'(5));
    check("t6_rst_vld", int'(bus.dout_valid), 0);
    check("t6_rst_i0", int'(bus.dout_i[0]), 0);
    clr();
    for (int n = 0; n < 20; n++)
      step(1, 1, 0, sample_t'($urandom), sample_t'($urandom));
    check("t6_quiet", pulses.size(), 0);
    for (int n = 0; n < FRAME_LEN; n++)
      step(1, 1, n == 0,
           (n % 2 == 0) ? sample_t'(1023) : sample_t'(-1024),
           (n % 2 == 0) ? sample_t'(-1024) : sample_t'(1023));
    idle(2);
    check("t6_i0", int'(bus.dout_i[0]), 1023);
    check("t6_q0", int'(bus.dout_q[0]), -1024);
    check("t6_i15", int'(bus.dout_i[15]), -1024);

    // Random traffic with occasional sof and reset
    for (int k = 0; k < 6000; k++)
      step(($urandom % 1500) != 0, ($urandom % 10) < 7,
           ($urandom % 400) == 0,
           sample_t'($urandom), sample_t'($urandom));
    idle(3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
